// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbitrated mux with a one-entry registered output.
// Arbitration is round-robin from the last grant or fixed lowest-index priority.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic                 prio_mode,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  // Elaboration-time parameter sanity.
  if (N < 2) begin : g_n_check
    $error("rr_arb_mux: N must be at least 2");
  end
  if (SEL_W != $clog2(N)) begin : g_sel_w_check
    $error("rr_arb_mux: SEL_W must equal ceil(log2(N))");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [WIDTH-1:0]   data_arr [N];
  logic [SEL_W-1:0]   cand_c;
  logic [SEL_W-1:0]   win_c;
  logic               found_c;
  logic               space_c;
  logic               load_c;

  // Unpack the flat channel data bus into per-channel words.
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_arr[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Winner search: fixed scans from 0, round-robin scans from ptr+1 with wrap.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (prio_mode) begin
        cand_c = SEL_W'(k);
      end else begin
        cand_c = SEL_W'((32'(ptr_q) + 32'd1 + k) % N);
      end
      if (!found_c && in_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  // Output stage has room when empty or being drained this cycle.
  assign space_c = (state_q == EMPTY) | out_ready;
  assign load_c  = found_c & space_c;

  // Grant is one-hot on the winner only when the word can be taken.
  always_comb begin
    in_ready = '0;
    if (load_c) begin
      in_ready[win_c] = 1'b1;
    end
  end

  // Next-state and datapath: load beats drain, stall freezes everything.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;
    case (state_q)
      EMPTY: begin
        if (load_c) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (load_c) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load_c) begin
      out_data_d = data_arr[win_c];
      out_sel_d  = win_c;
      ptr_d      = win_c;
    end
  end

  // State and output registers; reset points ptr at N-1 so channel 0 goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= SEL_W'(N - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux (N=4, WIDTH=8) with hand-computed expectations.
module tb_rr_arb_mux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned SEL_W = 2;

  logic               clk;
  logic               reset_n;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               prio_mode;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [7:0] ch_data [4];
  logic [7:0] exp_d;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .prio_mode (prio_mode),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it on mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  // Synchronous-looking reset pulse, released away from the clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ch_data[0] = 8'h10;
    ch_data[1] = 8'h21;
    ch_data[2] = 8'h32;
    ch_data[3] = 8'h43;

    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    prio_mode = 1'b0;
    out_ready = 1'b1;

    // 1: reset state, then first single-requester transfer.
    repeat (2) @(posedge clk);
    #1;
    check_out("rst", 1'b0, 8'h00, 2'd0);
    check("rst.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 4'b0001;
    in_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
    #1;
    check("t1.in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("t1.out", 1'b1, 8'hA5, 2'd0);

    // 2: round-robin fairness from a fresh pointer.
    in_valid = '0;
    do_reset();
    in_data   = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    in_valid  = 4'b1111;
    prio_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr%0d.in_ready", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
      tick();
      exp_d = ch_data[i % 4];
      check_out($sformatf("rr%0d", i), 1'b1, exp_d, 2'(i % 4));
    end

    // 3: fixed priority, lowest requester wins repeatedly; then next lowest.
    prio_mode = 1'b1;
    in_valid  = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("fx%0d.in_ready", i), 32'(in_ready), 32'b0010);
      tick();
      check_out($sformatf("fx%0d", i), 1'b1, 8'h21, 2'd1);
    end
    in_valid = 4'b1100;
    #1;
    check("fx_drop.in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("fx_drop", 1'b1, 8'h32, 2'd2);

    // 4: backpressure holds everything; release replaces the word in one edge.
    prio_mode = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
      tick();
      check_out($sformatf("bp%0d", i), 1'b1, 8'h32, 2'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel.in_ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("bp_rel", 1'b1, 8'h43, 2'd3);

    // 5: one fixed-priority grant moves ptr to 1; round-robin resumes at 2.
    prio_mode = 1'b1;
    in_valid  = 4'b1110;
    #1;
    check("ms_fx.in_ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("ms_fx", 1'b1, 8'h21, 2'd1);
    prio_mode = 1'b0;
    in_valid  = 4'b1111;
    #1;
    check("ms_rr.in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("ms_rr", 1'b1, 8'h32, 2'd2);
    tick();
    check_out("ms_rr2", 1'b1, 8'h43, 2'd3);

    // 6: asynchronous reset mid-cycle while stalled drops the word at once.
    out_ready = 1'b0;
    #2;
    check("pre_rst.valid", 32'(out_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_rel.in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("arst_rel", 1'b1, 8'h10, 2'd0);

    // Drain with no requesters empties the stage and holds data/sel.
    in_valid = '0;
    #1;
    check("drain.in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("drain", 1'b0, 8'h10, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
